// File: rtl/shake_absorb_pad.sv
// Streaming SHAKE absorb front-end: packs words into RATE-bit blocks, applies domain byte + pad10*1.
// Optional ABSORB_STATS_EN adds blk_count/msg_count handshake counters.
//
// state   | meaning
// S_FILL  | accepting message words into the block buffer
// S_EMIT  | block presented, waiting on blk_ready
// S_PADBLK| building a pad-only block after a message that ended exactly on a block boundary
module shake_absorb_pad #(
    parameter int          RATE   = 1088,
    parameter int          WORD   = 64,
    parameter logic [7:0]  DSBYTE = 8'h1F
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD-1:0]              in_data,
    input  logic [$clog2(WORD/8):0]      in_bytes,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [RATE-1:0]              blk,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic                         blk_last
`ifdef ABSORB_STATS_EN
    ,
    output logic [15:0]                  blk_count,
    output logic [15:0]                  msg_count
`endif
);
    localparam int W   = RATE / WORD;
    localparam int WB  = WORD / 8;
    localparam int RB  = RATE / 8;
    localparam int WCW = $clog2(W);
    localparam int NBW = $clog2(WB) + 1;

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_PADBLK} state_t;

    state_t          r_state, w_state_nx;
    logic [RATE-1:0] r_buf, w_buf_nx;
    logic [WCW-1:0]  r_wcnt, w_wcnt_nx;
    logic            r_pad_pending, w_pad_nx;
    logic            r_blk_last, w_last_nx;
    logic [WORD-1:0] w_word;
    logic            w_acc;
    int              w_nb;
    int              w_p;

    assign in_ready  = (r_state == S_FILL) && reset;
    assign blk       = r_buf;
    assign blk_valid = (r_state == S_EMIT);
    assign blk_last  = r_blk_last;
    assign w_acc     = in_valid && in_ready;

    always_comb begin
        w_state_nx = r_state;
        w_buf_nx   = r_buf;
        w_wcnt_nx  = r_wcnt;
        w_pad_nx   = r_pad_pending;
        w_last_nx  = r_blk_last;
        w_nb       = (in_bytes > NBW'(WB)) ? WB : int'(in_bytes);
        w_p        = int'(r_wcnt) * WB + w_nb;
        w_word     = in_data;
        for (int b = 0; b < WB; b++) begin
            if (b >= w_nb) w_word[8*b +: 8] = 8'h00;
        end

        case (r_state)
            S_FILL: begin
                if (w_acc) begin
                    for (int i = 0; i < W; i++) begin
                        if (i == int'(r_wcnt)) w_buf_nx[WORD*i +: WORD] = in_last ? w_word : in_data;
                    end
                    if (in_last) begin
                        w_state_nx = S_EMIT;
                        w_wcnt_nx  = '0;
                        if (w_p < RB) begin
                            for (int j = 0; j < RB; j++) begin
                                if (j == w_p) w_buf_nx[8*j +: 8] = w_buf_nx[8*j +: 8] ^ DSBYTE;
                            end
                            w_buf_nx[8*(RB-1) +: 8] = w_buf_nx[8*(RB-1) +: 8] ^ 8'h80;
                            w_last_nx = 1'b1;
                        end else begin
                            // message filled the block exactly: padding spills into its own block
                            w_last_nx = 1'b0;
                            w_pad_nx  = 1'b1;
                        end
                    end else if (r_wcnt == WCW'(W-1)) begin
                        w_state_nx = S_EMIT;
                        w_wcnt_nx  = '0;
                        w_last_nx  = 1'b0;
                    end else begin
                        w_wcnt_nx = r_wcnt + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    w_last_nx = 1'b0;
                    if (r_pad_pending) begin
                        w_state_nx = S_PADBLK;
                    end else begin
                        w_state_nx = S_FILL;
                        w_buf_nx   = '0;
                    end
                end
            end
            S_PADBLK: begin
                w_buf_nx                = '0;
                w_buf_nx[7:0]           = DSBYTE;
                w_buf_nx[8*(RB-1) +: 8] = w_buf_nx[8*(RB-1) +: 8] | 8'h80;
                w_last_nx               = 1'b1;
                w_pad_nx                = 1'b0;
                w_state_nx              = S_EMIT;
            end
            default: w_state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FILL;
            r_buf         <= '0;
            r_wcnt        <= '0;
            r_pad_pending <= 1'b0;
            r_blk_last    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_buf         <= w_buf_nx;
            r_wcnt        <= w_wcnt_nx;
            r_pad_pending <= w_pad_nx;
            r_blk_last    <= w_last_nx;
        end
    end

`ifdef ABSORB_STATS_EN
    logic [15:0] r_blk_count, r_msg_count;
    assign blk_count = r_blk_count;
    assign msg_count = r_msg_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blk_count <= '0;
            r_msg_count <= '0;
        end else if (blk_valid && blk_ready) begin
            r_blk_count <= r_blk_count + 16'd1;
            if (r_blk_last) r_msg_count <= r_msg_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shake_absorb_pad.sv
// Randomized bench for shake_absorb_pad against a byte-level pad10*1 reference model.
module tb_shake_absorb_pad;
    localparam int RATE = 1088;
    localparam int WORD = 64;
    localparam int RB   = RATE / 8;
    localparam int W    = RATE / WORD;
    localparam logic [7:0] DS = 8'h1F;

    typedef logic [RATE-1:0] wide_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [WORD-1:0] in_data = '0;
    logic [3:0]      in_bytes = '0;
    logic            in_last = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    wide_t           blk;
    logic            blk_valid;
    logic            blk_ready;
    logic            blk_last;

    int    n_chk = 0;
    int    n_err = 0;
    int    rdy_mode = 1;
    wide_t exp_blk[$];
    logic  exp_last[$];
    wide_t last_seen = '0;
    wide_t b0;
    logic  l0;

    shake_absorb_pad dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_bytes(in_bytes),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .blk(blk), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input wide_t got, input wide_t exp);
        int idx;
        n_chk++;
        if (got !== exp) begin
            n_err++;
            idx = 0;
            for (int i = W - 1; i >= 0; i--) if (got[64*i +: 64] !== exp[64*i +: 64]) idx = i;
            $display("FAIL %s word%0d got=%h exp=%h", tag, idx, got[64*idx +: 64], exp[64*idx +: 64]);
        end
    endtask

    // pad10*1 over the whole message, then slice into rate-sized blocks
    task automatic model(input byte unsigned msg[$]);
        int L, nblk;
        byte unsigned pad[];
        wide_t v;
        L    = msg.size();
        nblk = L / RB + 1;
        pad  = new[nblk * RB];
        foreach (msg[i]) pad[i] = msg[i];
        pad[L]           = pad[L] ^ DS;
        pad[nblk*RB - 1] = pad[nblk*RB - 1] ^ 8'h80;
        for (int b = 0; b < nblk; b++) begin
            v = '0;
            for (int j = 0; j < RB; j++) v[8*j +: 8] = pad[b*RB + j];
            exp_blk.push_back(v);
            exp_last.push_back(b == nblk - 1);
        end
    endtask

    // call at posedge+#1; returns at posedge+#1 after the final accepting edge
    task automatic send_msg(input int nfull, input int nb, input bit do_last,
                            input bit use_lw, input logic [63:0] lw);
        byte unsigned msg[$];
        logic [63:0]  words[$];
        int           nw, t, nbc;
        bit           acc, is_last;
        nw  = nfull + (do_last ? 1 : 0);
        nbc = (nb > 8) ? 8 : nb;
        for (int k = 0; k < nw; k++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            is_last = do_last && (k == nfull);
            if (is_last && use_lw) d = lw;
            words.push_back(d);
            for (int b = 0; b < (is_last ? nbc : 8); b++) msg.push_back(d[8*b +: 8]);
        end
        if (do_last) model(msg);
        for (int k = 0; k < nw; k++) begin
            is_last = do_last && (k == nfull);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_data  = words[k];
            in_last  = is_last;
            in_bytes = is_last ? 4'(nb) : 4'($urandom_range(0, 15));
            in_valid = 1'b1;
            acc = 0;
            t   = 0;
            while (!acc && t < 200) begin
                @(negedge clk); acc = in_ready;
                @(posedge clk); #1; t++;
            end
            if (!acc) chk("accept_timeout", wide_t'(0), wide_t'(1));
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_blk.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
        chk("drain", wide_t'(exp_blk.size()), wide_t'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_latency();
        @(negedge clk);
        chk("latency", wide_t'(blk_valid), wide_t'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        wide_t b;
        logic  l;
        blk_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       blk_ready = 1'($urandom_range(0, 1));
                1:       blk_ready = 1'b1;
                default: blk_ready = 1'b0;
            endcase
            @(negedge clk);
            if (reset && blk_valid && blk_ready) begin
                if (exp_blk.size() == 0) begin
                    chk("extra_blk", wide_t'(1), wide_t'(0));
                end else begin
                    b = exp_blk.pop_front();
                    l = exp_last.pop_front();
                    chk("blk", blk, b);
                    chk("blk_last", wide_t'(blk_last), wide_t'(l));
                    last_seen = blk;
                end
            end
        end
    end

    initial begin
        int t;
        #3;
        chk("rst_in_ready", wide_t'(in_ready), wide_t'(0));
        chk("rst_blk_valid", wide_t'(blk_valid), wide_t'(0));
        chk("rst_blk", blk, wide_t'(0));
        chk("rst_blk_last", wide_t'(blk_last), wide_t'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", wide_t'(in_ready), wide_t'(1));
        @(posedge clk); #1;

        // empty message
        send_msg(0, 0, 1, 0, '0);
        check_latency();
        drain();

        // 16 full words + 7 bytes: combined 0x9F pad byte
        send_msg(16, 7, 1, 0, '0);
        check_latency();
        drain();

        // 17 full words: data block then separate pad block, in_ready low throughout
        send_msg(16, 8, 1, 0, '0);
        @(negedge clk);
        chk("b2b_v1", wide_t'({blk_valid, blk_last, in_ready}), wide_t'(3'b100));
        @(negedge clk);
        chk("b2b_pad", wide_t'({blk_valid, in_ready}), wide_t'(2'b00));
        @(negedge clk);
        chk("b2b_v2", wide_t'({blk_valid, blk_last, in_ready}), wide_t'(3'b110));
        @(negedge clk);
        chk("b2b_fill", wide_t'(in_ready), wide_t'(1));
        @(posedge clk); #1;
        drain();

        // 3-byte message under backpressure
        rdy_mode = 2;
        send_msg(0, 3, 1, 1, 64'h0000_0000_000C_0B0A);
        @(negedge clk);
        chk("bp_latency", wide_t'(blk_valid), wide_t'(1));
        b0 = blk;
        l0 = blk_last;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_data  = {$urandom, $urandom};
            in_last  = 1'($urandom_range(0, 1));
            in_bytes = 4'($urandom_range(0, 8));
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_hold", {blk[RATE-1:3], blk_valid, blk_last, in_ready}, {b0[RATE-1:3], 1'b1, l0, 1'b0});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rdy_mode = 1;
        drain();
        t = 0;
        while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
        chk("bp_resume", wide_t'(in_ready), wide_t'(1));

        // reset after 5 accepted words
        send_msg(5, 0, 0, 0, '0);
        reset = 1'b0;
        #1;
        chk("mid_rst", {blk[RATE-1:2], blk_valid, in_ready}, wide_t'(0));
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", wide_t'(in_ready), wide_t'(1));
        @(posedge clk); #1;
        send_msg(0, 3, 1, 1, 64'h0000_0000_000C_0B0A);
        check_latency();
        drain();
        chk("rst_same_blk", last_seen, b0);

        // randomized messages with random backpressure, including clamped in_bytes
        rdy_mode = 0;
        for (int m = 0; m < 25; m++) begin
            send_msg($urandom_range(0, 40), $urandom_range(0, 15), 1, 0, '0);
            check_latency();
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
